// File: rtl/spi_sram_pkg.sv
// Shared opcodes, FSM encoding and field widths for the SPI SRAM command sequencer.
package spi_sram_pkg;

    localparam logic [7:0] CMD_RD = 8'h03;
    localparam logic [7:0] CMD_WR = 8'h02;

    localparam int BIDX_W = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_RDSHIFT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Frame order on the wire: opcode, address high, address low, data.
    function automatic logic [7:0] txByte(input logic [BIDX_W-1:0] bidx,
                                          input logic              rw,
                                          input logic [15:0]       addr,
                                          input logic [7:0]        wrData);
        logic [7:0] b;
        case (bidx)
            2'd0:    b = rw ? CMD_RD : CMD_WR;
            2'd1:    b = addr[15:8];
            2'd2:    b = addr[7:0];
            default: b = wrData;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sram_seq_bit_ctr.sv
// Bit counter shared by the transmit and receive phases: loads to 1, counts up, flags 8.
module spi_bit_ctr
    import spi_sram_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == CNT_W'(8));

endmodule

// File: rtl/spi_sram_seq.sv
// SPI SRAM command sequencer: frames single-byte reads/writes for the transmit buffer.
// Optional multi-byte burst continuation is enabled by defining SPI_SEQ_BURST_EN.
module spi_sram_seq
    import spi_sram_pkg::*;
(
    input  logic        sck_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        rw_i,
    input  logic [15:0] Addr_i,
    input  logic [7:0]  WrData_i,
    input  logic        sdi_i,
`ifdef SPI_SEQ_BURST_EN
    input  logic        more_i,
`endif
    output logic [7:0]  ParallelIn_o,
    output logic        LoadTx_o,
    output logic        ShiftTx_o,
    output logic [3:0]  TxCount_o,
    output logic        cs_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  RdData_o,
    output logic        RdValid_o
);

    state_e              state_q, state_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic                rw_q, rw_d;
    logic [15:0]         addr_q, addr_d;
    logic [7:0]          wrData_q, wrData_d;
    logic [7:0]          pinHold_q, pinHold_d;
    logic [7:0]          shReg_q, shReg_d;
    logic [7:0]          rdData_q, rdData_d;
    logic                rdValid_q, rdValid_d;
    logic                ctrLoad, ctrInc, ctrTerm;
    logic [CNT_W-1:0]    ctrCnt;
    logic                burstMore;

`ifdef SPI_SEQ_BURST_EN
    assign burstMore = more_i;
`else
    assign burstMore = 1'b0;
`endif

    spi_bit_ctr u_bit_ctr (
        .clk_i   (sck_i),
        .rst_n_i (rst_n_i),
        .load_i  (ctrLoad),
        .inc_i   (ctrInc),
        .cnt_o   (ctrCnt),
        .term_o  (ctrTerm)
    );

    always_ff @(posedge sck_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrLoad = 1'b0;
        ctrInc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                ctrLoad = 1'b1;
            end
            ST_SHIFT: begin
                if (!ctrTerm) begin
                    ctrInc = 1'b1;
                end else if (bidx_q == BIDX_W'(3)) begin
                    state_d = burstMore ? ST_LOAD : ST_DONE;
                end else if (bidx_q == BIDX_W'(2) && rw_q) begin
                    state_d = ST_RDSHIFT;
                    ctrLoad = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RDSHIFT: begin
                if (!ctrTerm) begin
                    ctrInc = 1'b1;
                end else if (burstMore) begin
                    ctrLoad = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The last byte of a read is taken straight from sdi so RdData is valid in DONE.
    always_comb begin
        bidx_d    = bidx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wrData_d  = wrData_q;
        pinHold_d = pinHold_q;
        shReg_d   = shReg_q;
        rdData_d  = rdData_q;
        rdValid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rw_d     = rw_i;
                    addr_d   = Addr_i;
                    wrData_d = WrData_i;
                    bidx_d   = '0;
                end
            end
            ST_LOAD: pinHold_d = txByte(bidx_q, rw_q, addr_q, wrData_q);
            ST_SHIFT: begin
                if (ctrTerm) begin
                    if (bidx_q == BIDX_W'(3)) begin
                        if (burstMore) wrData_d = WrData_i;
                    end else if (!(bidx_q == BIDX_W'(2) && rw_q)) begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end
            end
            ST_RDSHIFT: begin
                shReg_d = {shReg_q[6:0], sdi_i};
                if (ctrTerm) begin
                    rdData_d  = {shReg_q[6:0], sdi_i};
                    rdValid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sck_i) begin
        if (!rst_n_i) begin
            bidx_q    <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wrData_q  <= '0;
            pinHold_q <= '0;
            shReg_q   <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            bidx_q    <= bidx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wrData_q  <= wrData_d;
            pinHold_q <= pinHold_d;
            shReg_q   <= shReg_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    always_comb begin
        ParallelIn_o = pinHold_q;
        LoadTx_o     = 1'b0;
        ShiftTx_o    = 1'b0;
        TxCount_o    = '0;
        cs_n_o       = 1'b1;
        busy_o       = (state_q != ST_IDLE);
        done_o       = 1'b0;
        case (state_q)
            ST_LOAD: begin
                LoadTx_o     = 1'b1;
                cs_n_o       = 1'b0;
                ParallelIn_o = txByte(bidx_q, rw_q, addr_q, wrData_q);
            end
            ST_SHIFT: begin
                ShiftTx_o = 1'b1;
                TxCount_o = ctrCnt;
                cs_n_o    = 1'b0;
            end
            ST_RDSHIFT: cs_n_o = 1'b0;
            ST_DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign RdData_o  = rdData_q;
    assign RdValid_o = rdValid_q;

endmodule

// File: doc/spi_sram_seq.md
# spi_sram_seq

Command sequencer that feeds the SPI transmit buffer of the SRAM interface. It accepts single-byte read/write requests from the host, frames them as SPI SRAM transactions (opcode, 16-bit address, data), and drives the transmit buffer's load/shift/count controls and chip select. It also deserialises the read data returned on `sdi`. The block runs on the SPI clock domain.

## Interface
- `CMD_RD`, 8'h03: SRAM read opcode.
- `CMD_WR`, 8'h02: SRAM write opcode.
- `sck` in 1: clock; all state updates on the rising edge. The transmit buffer consumes `LoadTx`/`ShiftTx`/`TxCount` on the falling edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `rw` in 1: 1 = read, 0 = write; latched with `start`.
- `Addr` in 16: SRAM address; latched with `start`.
- `WrData` in 8: write byte; latched with `start`.
- `sdi` in 1: serial data from SRAM, MSB first.
- `ParallelIn` out 8: byte presented to the transmit buffer.
- `LoadTx` out 1: load strobe to the transmit buffer.
- `ShiftTx` out 1: shift enable to the transmit buffer. When low, the buffer tri-states `sdo`.
- `TxCount` out 4: bit index to the transmit buffer, 1..8; 0 when not shifting.
- `cs_n` out 1: SRAM chip select, active low.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `RdData` out 8: last read byte; holds until the next read completes.
- `RdValid` out 1: one-cycle pulse coincident with `done` on reads.

## Operation
- Moore FSM with states IDLE, LOAD, SHIFT, RDSHIFT, DONE.
- Byte index `bidx` (0..3) selects the byte sent:
  - 0: opcode (`CMD_RD` or `CMD_WR`)
  - 1: `Addr[15:8]`
  - 2: `Addr[7:0]`
  - 3: `WrData`
- IDLE:
  - `start`=1 latches `rw`, `Addr`, `WrData` and sets `bidx`=0 → LOAD.
- LOAD:
  - `LoadTx`=1 and `ParallelIn`=byte[`bidx`] → SHIFT with bit counter = 1.
- SHIFT:
  - `ShiftTx`=1 and `TxCount`=bit counter; the counter increments 1→8, which sends MSB first.
  - At count 8: if `bidx`<2, or `bidx`=2 on a write, increment `bidx` → LOAD.
  - If `bidx`=2 on a read → RDSHIFT with counter = 1.
  - If `bidx`=3 → DONE.
- RDSHIFT:
  - `ShiftTx`=0 and `TxCount`=0.
  - Each cycle shifts `sdi` into the LSB of a shift register (left shift).
  - At count 8, the shift register is copied to `RdData` → DONE.
- DONE:
  - `cs_n`=1, `done`=1, and `RdValid`=`rw` for one cycle → IDLE.
- `cs_n`=0 in LOAD, SHIFT and RDSHIFT; 1 otherwise.
- `busy`=1 in every state except IDLE.
- `ParallelIn` holds its last value outside LOAD.
- `start` while busy is ignored; there is no queueing.
- Reset values: `cs_n`=1, `LoadTx`=0, `ShiftTx`=0, `TxCount`=0, `ParallelIn`=0, `busy`=0, `done`=0, `RdValid`=0, `RdData`=0, state IDLE.
- Reset asserted mid-transaction: IDLE and `cs_n`=1 at the next edge. No `done` or `RdValid` is produced and `RdData` is cleared.

## Timing
- `start` sampled at edge 0 → LOAD during cycle 1.
- Each transmitted byte costs 9 cycles: 1 LOAD + 8 SHIFT.
- Write: 36 cycles of `cs_n` low, `done` in cycle 37, next `start` accepted at the edge ending cycle 38 (IDLE).
- Read: 27 cycles for 3 bytes, then 8 RDSHIFT cycles (35 cycles of `cs_n` low), `done`/`RdValid` in cycle 36.
- `TxCount` is stable for the full cycle, so the falling-edge consumer sees a settled value.
- `sdi` is sampled on the rising edge. The SRAM is required to drive data off the preceding falling edge.

## Configuration
- `SPI_SEQ_BURST_EN` defined:
  - Adds input `more` (1 bit).
  - In SHIFT at count 8 with `bidx`=3, or in RDSHIFT at count 8: if `more`=1, stay in the data phase with `cs_n` held low.
    - Write: `WrData` is re-latched → LOAD with `bidx`=3.
    - Read: `RdData` updates, `RdValid` pulses for one cycle, and the counter restarts at 1 in RDSHIFT.
  - `more`=0 → DONE as normal.
  - Host increments address implicitly (SRAM sequential mode).
- `SPI_SEQ_BURST_EN` undefined: no `more` port; every transaction is exactly one data byte.

## Structure
- Package `spi_sram_pkg`:
  - `CMD_RD`, `CMD_WR` opcodes.
  - FSM state encoding (3-bit).
  - Byte-index and bit-count widths.
- Sub-module `spi_bit_ctr`: 4-bit counter with load-to-1, increment, and a terminal flag at 8, shared by SHIFT and RDSHIFT.

## Test plan
- Write: `start`, `rw`=0, `Addr`=16'h1234, `WrData`=8'hA5 → `ParallelIn` sequence 02, 12, 34, A5 on the four `LoadTx` pulses; `TxCount` 1..8 after each; `cs_n` low for 36 cycles; `done` in cycle 37.
- Read: `rw`=1, `Addr`=16'h00FF, bench drives 8'h3C on `sdi` MSB first in RDSHIFT → `RdData`=8'h3C, `RdValid`=`done`=1 in cycle 36, `ShiftTx`=0 throughout RDSHIFT.
- `start` pulsed every cycle during a write → exactly one transaction; second `start` accepted only in IDLE.
- `rst_n`=0 at cycle 20 of a read → `cs_n`=1 and `busy`=0 next edge, no `done`, `RdData`=0.
- Reset values checked on all outputs after 3 reset cycles with random inputs.
- `SPI_SEQ_BURST_EN`: read, `more`=1 for two bytes (8'h11, 8'h22) → two `RdValid` pulses with `cs_n` continuously low; final `done` after the second byte.
